// File: rtl/decrypt.sv
// Iterative AES-128 inverse cipher, one round per clock. Round keys arrive
// combinationally from an external key expander addressed by the registered `round`.
module decrypt (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [127:0] ciphertext,
    input  logic [127:0] round_key,
    output logic [3:0]   round,
    output logic [127:0] plaintext,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = 11'd2047 - {x, 3'b000};
        return INV_SBOX[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = inv_sbox(s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
            end
        end
        return o;
    endfunction

    // Column-wise multiply by {0e,0b,0d,09} built from repeated xtime.
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        logic [7:0]   x2, x4, x8;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[127 - 8*(r + 4*c) -: 8];
                x2    = xtime(a[r]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            o[127 - 32*c -: 8]      = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[127 - 32*c - 8 -: 8]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[127 - 32*c - 16 -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[127 - 32*c - 24 -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

    state_t       r_state;
    logic [3:0]   r_round;
    logic [127:0] r_st;
    logic [127:0] r_plaintext;
    logic         r_busy;
    logic         r_done;

    state_t       w_state_n;
    logic [3:0]   w_round_n;
    logic [127:0] w_st_n;
    logic [127:0] w_plaintext_n;
    logic         w_busy_n;
    logic         w_done_n;
    logic [127:0] w_ark;
    logic [127:0] w_mixed;

    assign w_ark   = inv_shift_sub(r_st) ^ round_key;
    assign w_mixed = inv_mix_columns(w_ark);

    // Next-state and datapath selection; abort and illegal round both fall back to IDLE.
    always_comb begin
        w_state_n     = r_state;
        w_round_n     = r_round;
        w_st_n        = r_st;
        w_plaintext_n = r_plaintext;
        w_busy_n      = r_busy;
        w_done_n      = 1'b0;
        if (r_round > 4'd10) begin
            w_state_n = S_IDLE;
            w_round_n = 4'd10;
            w_busy_n  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        w_st_n    = ciphertext ^ round_key;
                        w_round_n = 4'd9;
                        w_busy_n  = 1'b1;
                        w_state_n = S_ROUND;
                    end else begin
                        w_round_n = 4'd10;
                        w_busy_n  = 1'b0;
                    end
                end
                S_ROUND: begin
                    if (!en || r_round == 4'd0) begin
                        w_state_n = S_IDLE;
                        w_round_n = 4'd10;
                        w_busy_n  = 1'b0;
                    end else begin
                        w_st_n    = w_mixed;
                        w_round_n = r_round - 4'd1;
                        if (r_round == 4'd1) begin
                            w_state_n = S_FINAL;
                        end else begin
                            w_state_n = S_ROUND;
                        end
                    end
                end
                S_FINAL: begin
                    if (!en) begin
                        w_state_n = S_IDLE;
                        w_round_n = 4'd10;
                        w_busy_n  = 1'b0;
                    end else begin
                        w_plaintext_n = w_ark;
                        w_done_n      = 1'b1;
                        w_busy_n      = 1'b0;
                        w_round_n     = 4'd10;
                        w_state_n     = S_IDLE;
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                    w_round_n = 4'd10;
                    w_busy_n  = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_round     <= 4'd10;
            r_st        <= 128'h0;
            r_plaintext <= 128'h0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_round     <= w_round_n;
            r_st        <= w_st_n;
            r_plaintext <= w_plaintext_n;
            r_busy      <= w_busy_n;
            r_done      <= w_done_n;
        end
    end

    assign round     = r_round;
    assign plaintext = r_plaintext;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_decrypt.sv
// Self-checking bench for decrypt: reference key expansion and forward cipher
// built from a computed S-box, vector table, scoreboard and corner-case sequences.
module tb_decrypt;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [127:0] ciphertext;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic [127:0] plaintext;
    logic         busy;
    logic         done;

    decrypt dut (
        .clk(clk), .rst(rst), .en(en), .ciphertext(ciphertext), .round_key(round_key),
        .round(round), .plaintext(plaintext), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    logic [7:0]   sb [256];
    logic [127:0] rk_tab [11];
    logic [127:0] exp_q [$];
    int           n_tests = 0;
    int           n_fail  = 0;

    // Key expander stand-in: combinational round-key lookup.
    assign round_key = (round <= 4'd10) ? rk_tab[round] : 128'h0;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] x;
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            p = 8'h01;
            for (int k = 0; k < 254; k++) p = gm(p, x);
            if (i == 0) p = 8'h00;
            sb[i] = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
        end
    endtask

    task automatic key_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s, t, m;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ rk_tab[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++)
                t[127 - 8*i -: 8] = sb[s[127 - 8*((i % 4) + 4*(((i / 4) + (i % 4)) % 4)) -: 8]];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127 - 32*c -: 8];      a1 = t[119 - 32*c -: 8];
                    a2 = t[111 - 32*c -: 8];      a3 = t[103 - 32*c -: 8];
                    m[127 - 32*c -: 8] = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    m[119 - 32*c -: 8] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    m[111 - 32*c -: 8] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    m[103 - 32*c -: 8] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
                t = m;
            end
            s = t ^ rk_tab[r];
        end
        return s;
    endfunction

    // Scoreboard: every done pulse pops the oldest expected plaintext.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no done, plaintext %h", plaintext);
            end else begin
                check("plaintext", plaintext, exp_q.pop_front());
            end
        end
    end

    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input bit chk_rounds);
        int         n;
        bit         seen;
        bit         busy_ok;
        logic [3:0] rseq [12];
        @(negedge clk);
        rseq[0]    = round;
        ciphertext = ct;
        en         = 1'b1;
        exp_q.push_back(pt);
        @(posedge clk);
        n = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n <= 11) rseq[n] = round;
            if (n == 2) ciphertext = ~ct;
            if (done === 1'b1) seen = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        en = 1'b0;
        check("latency_edges", 128'(n - 1), 128'd10);
        check("busy_profile", {busy_ok, busy}, 128'b10);
        if (chk_rounds) begin
            for (int k = 0; k < 12; k++)
                check("round_seq", 128'(rseq[k]), (k == 0 || k == 11) ? 128'd10 : 128'(10 - k));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  dn;
        rst = 1'b1; en = 1'b0; ciphertext = 128'h0;
        build_sbox();
        vecs[0] = '{KEY_C1, CT_C1, PT_C1};
        vecs[1] = '{KEY_B, CT_B, PT_B};
        vecs[2] = '{KEY_B, 128'h0, 128'h2};
        for (int i = 3; i < 8; i++)
            vecs[i] = '{{$urandom, $urandom, $urandom, $urandom}, 128'h0,
                        {$urandom, $urandom, $urandom, $urandom}};
        for (int i = 2; i < 8; i++) begin
            key_expand(vecs[i].key);
            vecs[i].ct = encrypt(vecs[i].pt);
        end

        #2;
        check("reset_outputs", {round, plaintext, busy, done}, {4'd10, 128'h0, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            key_expand(vecs[i].key);
            run_block(vecs[i].ct, vecs[i].pt, i == 1);
        end

        // Abort: en dropped before E5.
        key_expand(KEY_C1);
        @(negedge clk);
        ciphertext = CT_C1; en = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("abort_state", {busy, round, done}, {1'b0, 4'd10, 1'b0});
        dn = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0) dn = 1'b1;
        end
        check("abort_no_done", 128'(dn), 128'd0);
        check("abort_plaintext_held", plaintext, vecs[7].pt);

        // Back-to-back: ciphertext switched mid-block, key switched at completion.
        @(negedge clk);
        ciphertext = CT_C1; en = 1'b1;
        exp_q.push_back(PT_C1);
        @(posedge clk);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                ciphertext = CT_B;
                exp_q.push_back(PT_B);
            end
        end
        check("b2b_first_latency", 128'(n - 1), 128'd10);
        key_expand(KEY_B);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 25);
        en = 1'b0;
        check("b2b_done_spacing", 128'(n), 128'd11);

        // Asynchronous reset in the middle of a decryption.
        key_expand(KEY_C1);
        @(negedge clk);
        ciphertext = CT_C1; en = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_reset", {round, plaintext, busy, done}, {4'd10, 128'h0, 1'b0, 1'b0});
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_idle", {round, busy, done}, {4'd10, 1'b0, 1'b0});
        run_block(CT_C1, PT_C1, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decrypt.md
# decrypt

Iterative AES-128 decryption core, one round per clock: the inverse of the `encrypt` block, in the same datapath. It takes a 128-bit ciphertext and produces the plaintext after 11 clock edges. It consumes round keys from the existing `keyExpan` instance, which is shared or duplicated. It drives `round` (10 down to 0) to that instance and expects the matching round key back combinationally in the same cycle. Key expansion must be complete (its `ke_en` phase finished) before `en` is raised.

## Interface
- No parameters. Fixed AES-128, Nr = 10.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  level request. Sampled high in IDLE, it starts a decryption.
- `ciphertext`  input  128  block to decrypt. Byte 0 is bits [127:120]. Sampled only on the start edge.
- `round_key`  input  128  round key for the current `round` value, combinational from `keyExpan`.
- `round`  output  4  index of the round key required this cycle; registered.
- `plaintext`  output  128  result register. Updated only on completion.
- `busy`  output  1  high while a decryption is in progress.
- `done`  output  1  one-cycle pulse, coincident with the cycle in which new `plaintext` first appears.

## Operation
- The state is a 128-bit register `st`, with the FIPS-197 column-major byte order used by `encrypt`.
- FSM states: IDLE, ROUND, FINAL.
- IDLE: `round` = 10, `busy` = 0.
  - On an edge with `en` = 1: `st` <= `ciphertext ^ round_key` (rk10), `round` <= 9, go to ROUND, `busy` <= 1.
- ROUND (`round` 9..1), on each edge:
  - `st` <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(st)), round_key)).
  - `round` <= `round` - 1.
  - When the old `round` was 1, go to FINAL.
- FINAL (`round` = 0), on the edge:
  - `plaintext` <= AddRoundKey(InvSubBytes(InvShiftRows(st)), rk0).
  - `done` <= 1, `busy` <= 0, `round` <= 10, go to IDLE.
- InvSubBytes: 16 combinational inverse S-box lookups. InvMixColumns: GF(2^8) multiply by 0e/0b/0d/09 with reduction polynomial 0x11b.
- Abort: if `en` is 0 on any edge in ROUND or FINAL, go to IDLE. `round` <= 10, `busy` <= 0, `done` stays 0, `plaintext` is unchanged.
- Back-to-back: `en` held high through the completion cycle starts the next decryption on the following edge. That decryption uses the `ciphertext` value present at that edge.
- A change on `ciphertext` while busy has no effect on the decryption in progress.
- `round` values 11..15 are unreachable. If one is ever seen, the FSM returns to IDLE and `round` is forced to 10.

## Timing
- Reset values (asynchronous, immediate on `rst` high): `round` = 10, `plaintext` = 0, `busy` = 0, `done` = 0, `st` = 0, FSM = IDLE.
- Reset asserted mid-operation discards the operation. After release the block sits in IDLE and needs a fresh `en`.
- Latency, with E0 as the start edge:
  - E1..E9 run rounds 9..1.
  - E10 runs round 0 and loads `plaintext`; `done` is high in the cycle after E10.
  - Start-to-result latency is 10 cycles after E0. Throughput is one block per 11 cycles.
- `done` is high for exactly one cycle. `busy` falls on the same edge that raises `done`.
- `round` is registered, and `round_key` must settle within the same cycle. The critical path is the `round` register through `keyExpan` lookup, InvSubBytes, AddRoundKey and InvMixColumns into `st`.

## Test plan
- FIPS-197 C.1:
  - Expand key 000102030405060708090a0b0c0d0e0f.
  - Drive ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a with `en` = 1 for 11 cycles.
  - Expect `plaintext` = 00112233445566778899aabbccddeeff, with `done` pulsing exactly 10 cycles after the start edge.
- FIPS-197 App. B:
  - Expand key 2b7e151628aed2a6abf7158809cf4f3c.
  - Decrypt 3925841d02dc09fbdc118597196a0b32.
  - Expect 3243f6a8885a308d313198a2e0370734.
  - Check the `round` sequence 10, 9, 8, …, 0, 10.
- Round trip with `encrypt`:
  - Key 2b7e151628aed2a6abf7158809cf4f3c.
  - Encrypt 00000000000000000000000000000002, then decrypt the result.
  - Expect 00000000000000000000000000000002.
- Abort:
  - Start C.1, drop `en` at E5.
  - Expect `busy` = 0, `round` = 10, no `done`, and `plaintext` still holding its previous value.
- Back-to-back:
  - Hold `en` high across two blocks, with the ciphertext switched to the App. B vector during the first block.
  - Expect the first result to be the C.1 plaintext.
  - Expect the second result to be the App. B plaintext, with its `done` arriving 11 cycles after the first.
- Reset:
  - Assert `rst` at E4 of a decryption.
  - Expect all outputs at their reset values immediately, without waiting for a clock edge.
  - A subsequent C.1 run must succeed.
